// File: rtl/sd_pattern_tx.sv
// sd_pattern_tx: serialises a fixed or runtime pattern MSB first, repeated with optional zero gaps.
module sd_pattern_tx #(
  parameter int PAT_W = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b110011,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_pat_in,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);
  localparam int IW = PAT_W > 1 ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d, gl_q, gl_d, gcnt_q, gcnt_d;
  logic [PAT_W-1:0] pat_q, pat_d, sel;
  logic out_q, out_d, valid_q, valid_d, done_q, done_d, ready_q, ready_d;
  assign sel = use_pat_in ? pat_in : PATTERN;
  // rep_q counts repetitions still to send, including the one in flight
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rep_d = rep_q;
    gl_d = gl_q;
    gcnt_d = gcnt_q;
    pat_d = pat_q;
    out_d = out_q;
    valid_d = valid_q;
    done_d = 1'b0;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        pat_d = sel;
        rep_d = repeat_n == '0 ? CNT_W'(1) : repeat_n;
        gl_d = gap;
        idx_d = TOP;
        out_d = sel[PAT_W-1];
        valid_d = 1'b1;
        ready_d = 1'b0;
      end
      SEND: if (idx_q != '0) begin
        idx_d = idx_q - IW'(1);
        out_d = pat_q[idx_q - IW'(1)];
      end else if (rep_q > CNT_W'(1)) begin
        rep_d = rep_q - CNT_W'(1);
        state_d = gl_q != '0 ? GAP : SEND;
        gcnt_d = gl_q - CNT_W'(1);
        idx_d = TOP;
        out_d = gl_q != '0 ? 1'b0 : pat_q[PAT_W-1];
      end else begin
        state_d = DONE;
        out_d = 1'b0;
        valid_d = 1'b0;
        done_d = 1'b1;
      end
      GAP: if (gcnt_q == '0) begin
        state_d = SEND;
        idx_d = TOP;
        out_d = pat_q[PAT_W-1];
      end else gcnt_d = gcnt_q - CNT_W'(1);
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      rep_q <= '0;
      gl_q <= '0;
      gcnt_q <= '0;
      pat_q <= '0;
      out_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rep_q <= rep_d;
      gl_q <= gl_d;
      gcnt_q <= gcnt_d;
      pat_q <= pat_d;
      out_q <= out_d;
      valid_q <= valid_d;
      done_q <= done_d;
      ready_q <= ready_d;
    end
  end
  assign ready = ready_q;
  assign out = out_q;
  assign out_valid = valid_q;
  assign done = done_q;
endmodule

// File: tb/tb_sd_pattern_tx.sv
// tb_sd_pattern_tx: scoreboard bench; expected bits are queued at start and popped as out_valid bits appear.
module tb_sd_pattern_tx;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, use_pat_in = 1'b0;
  logic [5:0] pat_in = '0;
  logic [3:0] repeat_n = '0, gap = '0;
  logic ready, out, out_valid, done;
  int checks = 0, errors = 0;
  bit exp_q[$];
  int hits;
  sd_pattern_tx dut (
    .clk(clk), .reset(reset), .start(start), .use_pat_in(use_pat_in), .pat_in(pat_in),
    .repeat_n(repeat_n), .gap(gap), .ready(ready), .out(out), .out_valid(out_valid), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic up, input logic [5:0] pin, input logic [3:0] rn, input logic [3:0] g, input int poke);
    logic [5:0] p;
    logic [5:0] sh;
    int r, n, cyc, total;
    p = up ? pin : 6'b110011;
    r = rn == 0 ? 1 : int'(rn);
    total = r * 6 + (r - 1) * int'(g);
    exp_q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = 5; b >= 0; b--) exp_q.push_back(p[b]);
      if (k < r - 1) for (int z = 0; z < int'(g); z++) exp_q.push_back(1'b0);
    end
    check("ready_before", int'(ready), 1);
    use_pat_in = up; pat_in = pin; repeat_n = rn; gap = g; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; cyc = 0; hits = 0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) begin pat_in = ~pat_in; use_pat_in = ~use_pat_in; repeat_n = 4'd9; gap = 4'd7; end
      if (out_valid) begin
        n++;
        sh = {sh[4:0], out};
        if (n >= 6 && sh == 6'b110011) hits++;
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check("bit", int'(out), int'(exp_q.pop_front()));
        if (ready) check("ready_busy", int'(ready), 0);
        if (done) check("done_while_valid", int'(done), 0);
      end
      if (done) break;
      if (cyc > 1000) begin check("timeout", cyc, 0); break; end
    end
    start = 1'b0;
    check("queue_left", exp_q.size(), 0);
    check("nvalid", n, total);
    check("done_cycle", cyc, total + 1);
    check("done_ready", int'(ready), 0);
    check("done_valid", int'(out_valid), 0);
    @(negedge clk);
    check("idle_ready", int'(ready), 1);
    check("idle_done", int'(done), 0);
    check("idle_valid", int'(out_valid), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    send(1'b0, 6'b000000, 4'd1, 4'd0, 0);
    send(1'b0, 6'b000000, 4'd2, 4'd0, 0);
    check("b2b_hits", hits, 2);
    send(1'b1, 6'b101101, 4'd3, 4'd2, 0);
    send(1'b1, 6'b011010, 4'd0, 4'd3, 3);
    send(1'b1, 6'b100111, 4'd2, 4'd1, 8);
    send(1'b0, 6'b000000, 4'hF, 4'hF, 0);
    // reset on the third pattern bit
    use_pat_in = 1'b0; repeat_n = 4'd2; gap = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_valid", int'(out_valid), 1);
    check("mid_bit3", int'(out), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_valid", int'(out_valid), 0);
    check("abort_done", int'(done), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || out_valid) check("abort_quiet", int'({done, out_valid}), 0);
    end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_ready", int'(ready), 1);
    check("rst_start_valid", int'(out_valid), 0);
    send(1'b1, 6'b010101, 4'd1, 4'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
